// File: rtl/serial_tx_if.sv
// ---------------------------------------------------------------------------
// serial_tx_if
// Byte handshake between a producer and serial_tx.
//   tx_data  [7:0]  byte offered by the producer (sampled on handshake)
//   tx_valid        producer has a byte on tx_data
//   tx_ready        transmitter can accept a byte this cycle
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface serial_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
// Parallel-in, serial-out byte transmitter. Frame on tx_out:
//   start(0), d0..d7 (LSB first), [parity], stop(1); each bit CLKS_PER_BIT clks.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   s_if     byte handshake (tx_data / tx_valid in, tx_ready out)
//   tx_out   registered serial line, idles high
//   busy     frame in progress (state != IDLE)
//   bit_idx  index of data bit being driven, 0 outside DATA
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  serial_tx_if.slave        s_if,
  output logic              tx_out,
  output logic              busy,
  output logic [2:0]        bit_idx
);

  localparam int                 CNT_W   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [7:0]       r_shift,  w_shift_nxt;
  logic             r_par,    w_par_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic             r_tx_out, w_tx_out_nxt;
  logic             w_bit_end;

  assign w_bit_end     = (r_cnt == CNT_MAX);
  assign s_if.tx_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign bit_idx       = r_bit_idx;
  assign tx_out        = r_tx_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= 3'd0;
      r_tx_out  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx_out  <= w_tx_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_out_nxt  = 1'b1;

    // Baud counter runs in every non-idle state and wraps at each bit edge.
    if (r_state != S_IDLE)
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (s_if.tx_valid) begin
          w_state_nxt   = S_START;
          w_cnt_nxt     = '0;
          w_shift_nxt   = s_if.tx_data;
          w_par_nxt     = (^s_if.tx_data) ^ PARITY_ODD;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = 3'd0;
      end
    endcase

    // Line level is registered from the next state so tx_out lines up with
    // the state register and never glitches.
    case (w_state_nxt)
      S_START:  w_tx_out_nxt = 1'b0;
      S_DATA:   w_tx_out_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_out_nxt = w_par_nxt;
      default:  w_tx_out_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 4 clk/bit even parity; 1: odd parity; 2: no parity; 3: 1 clk/bit even.
  logic [3:0] vld;
  logic [7:0] dat [4];
  wire  [3:0] txo;
  wire  [3:0] bsy;
  wire  [3:0] rdy;
  logic [2:0] bidx [4];

  serial_tx_if if0 ();
  serial_tx_if if1 ();
  serial_tx_if if2 ();
  serial_tx_if if3 ();

  assign if0.tx_valid = vld[0]; assign if0.tx_data = dat[0]; assign rdy[0] = if0.tx_ready;
  assign if1.tx_valid = vld[1]; assign if1.tx_data = dat[1]; assign rdy[1] = if1.tx_ready;
  assign if2.tx_valid = vld[2]; assign if2.tx_data = dat[2]; assign rdy[2] = if2.tx_ready;
  assign if3.tx_valid = vld[3]; assign if3.tx_data = dat[3]; assign rdy[3] = if3.tx_ready;

  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .rst(rst), .s_if(if0), .tx_out(txo[0]), .busy(bsy[0]), .bit_idx(bidx[0]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
    .clk(clk), .rst(rst), .s_if(if1), .tx_out(txo[1]), .busy(bsy[1]), .bit_idx(bidx[1]));
  serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
    .clk(clk), .rst(rst), .s_if(if2), .tx_out(txo[2]), .busy(bsy[2]), .bit_idx(bidx[2]));
  serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u3 (
    .clk(clk), .rst(rst), .s_if(if3), .tx_out(txo[3]), .busy(bsy[3]), .bit_idx(bidx[3]));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk($sformatf("%s u%0d tx_out", tag, sel), 32'(txo[sel]), 32'd1);
    chk($sformatf("%s u%0d busy", tag, sel), 32'(bsy[sel]), 32'd0);
    chk($sformatf("%s u%0d tx_ready", tag, sel), 32'(rdy[sel]), 32'd1);
    chk($sformatf("%s u%0d bit_idx", tag, sel), 32'(bidx[sel]), 32'd0);
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the first START cycle.
  task automatic send_byte(input int sel, input logic [7:0] d);
    dat[sel] = d;
    vld[sel] = 1'b1;
    @(negedge clk);
  endtask

  // bits[k] = k-th bit on the line (bit 0 = start). At the first sample the
  // producer side is changed to mid_data / keep_vld to show it is ignored.
  task automatic check_frame(input int sel, input logic [10:0] bits, input int nbits,
                             input logic [7:0] mid_data, input logic keep_vld,
                             input string tag);
    int cpb;
    cpb = (sel == 3) ? 1 : 4;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s tx_out bit%0d clk%0d", tag, k, c), 32'(txo[sel]), 32'(bits[k]));
        chk($sformatf("%s busy bit%0d clk%0d", tag, k, c), 32'(bsy[sel]), 32'd1);
        chk($sformatf("%s tx_ready bit%0d clk%0d", tag, k, c), 32'(rdy[sel]), 32'd0);
        chk($sformatf("%s bit_idx bit%0d clk%0d", tag, k, c), 32'(bidx[sel]),
            (k >= 1 && k <= 8) ? 32'(k - 1) : 32'd0);
        if (k == 0 && c == 0) begin
          dat[sel] = mid_data;
          vld[sel] = keep_vld;
        end
        @(negedge clk);
      end
    end
    chk_idle(sel, {tag, " end"});
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [10:0] bits;   // {stop, parity, d7..d0, start} written out by hand
    int         nbits;
    string      tag;
  } vec_t;

  vec_t vecs [4];

  // CLKS_PER_BIT=1 stream decoder
  logic       mon_en = 1'b0;
  int         n_dec  = 0;
  logic [7:0] exp_q [$];

  initial begin
    int         d_st;
    int         d_cnt;
    logic [7:0] d_byte;
    logic       d_par;
    logic [7:0] e;
    d_st = 0; d_cnt = 0; d_byte = 8'h00; d_par = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        case (d_st)
          0: if (txo[3] == 1'b0) begin d_st = 1; d_cnt = 0; d_byte = 8'h00; end
          1: begin
               d_byte[d_cnt] = txo[3];
               d_cnt++;
               if (d_cnt == 8) d_st = 2;
             end
          2: begin d_par = txo[3]; d_st = 3; end
          default: begin
            if (exp_q.size() == 0) begin
              chk($sformatf("stream unexpected frame %0d", n_dec), 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("stream byte %0d", n_dec), 32'(d_byte), 32'(e));
              chk($sformatf("stream parity %0d", n_dec), 32'(d_par), 32'(^e));
            end
            chk($sformatf("stream stop %0d", n_dec), 32'(txo[3]), 32'd1);
            n_dec++;
            d_st = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic got;

    vld = 4'b0000;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;

    vecs[0] = '{0, 8'hA5, 11'b1_0_10100101_0, 11, "even A5"};
    vecs[1] = '{1, 8'h07, 11'b1_0_00000111_0, 11, "odd 07"};
    vecs[2] = '{2, 8'hFF, 11'b0_1_11111111_0, 10, "nopar FF"};
    vecs[3] = '{0, 8'h3C, 11'b1_0_00111100_0, 11, "even 3C"};

    // Reset asserted between clock edges must act at once.
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk_idle(i, "async reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "after reset release");

    // Reset mid-frame during data bit 3.
    send_byte(0, 8'h5A);
    vld[0] = 1'b0;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 64) begin
      if (bidx[0] == 3'd3 && bsy[0]) got = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    chk("reach bit_idx 3", 32'(got), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle(0, "mid-frame reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle(0, "post reset no byte retained");

    // Table of single frames.
    for (int v = 0; v < 4; v++) begin
      send_byte(vecs[v].sel, vecs[v].data);
      check_frame(vecs[v].sel, vecs[v].bits, vecs[v].nbits, ~vecs[v].data, 1'b0, vecs[v].tag);
      @(negedge clk);
    end

    // Back-to-back with tx_valid held high; data swapped to 80 during frame 1.
    send_byte(0, 8'h01);
    check_frame(0, 11'b1_1_00000001_0, 11, 8'h80, 1'b1, "b2b 01");
    @(negedge clk);
    check_frame(0, 11'b1_1_10000000_0, 11, 8'h00, 1'b0, "b2b 80");
    @(negedge clk);
    chk_idle(0, "b2b no resend");

    // Streaming at one clock per bit, decoded by the monitor above.
    mon_en = 1'b1;
    vld[3] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      waited = 0;
      while (!rdy[3] && waited < 64) begin @(negedge clk); waited++; end
      chk($sformatf("stream ready %0d", i), 32'(rdy[3]), 32'd1);
      dat[3] = b;
      vld[3] = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
    end
    vld[3] = 1'b0;
    waited = 0;
    while (n_dec < 16 && waited < 200) begin @(negedge clk); waited++; end
    chk("stream frames decoded", 32'(n_dec), 32'd16);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out byte transmitter. It is the sending end for the team's 8-bit serial-in shift register.
- Accepts one byte per valid/ready handshake.
- Frames the byte as: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Drives each bit for a fixed number of clocks.
- Sits between a byte producer (CPU-side or test logic) and the single-wire serial line.

Parameters:
CLKS_PER_BIT, 4, clocks each bit is held on tx_out; legal range 1..65535; counter width = clog2(CLKS_PER_BIT)+1.
PARITY_EN, 1, 1 = insert parity bit after data, 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity (data ones + parity bit is even), 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
tx_data  input  8  byte to send; sampled only on handshake.
tx_valid  input  1  producer has a byte on tx_data.
tx_ready  output  1  block can accept a byte this cycle.
tx_out  output  1  serial line; idle level 1.
busy  output  1  frame in progress (any state other than IDLE).
bit_idx  output  3  index of the data bit currently driven; 0 outside DATA.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - state=IDLE, tx_out=1, tx_ready=1, busy=0, bit_idx=0.
  - Baud counter and shift register are cleared to 0.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready = (state==IDLE); combinational from state only, with no dependency on tx_valid.
- IDLE:
  - tx_out=1.
  - On rising edge with tx_valid&&tx_ready: latch tx_data into the shift register, compute the parity bit from the latched byte, go to START, clear the baud counter.
- Bit timing: every non-IDLE state lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the state or bit advances on the edge where counter==CLKS_PER_BIT-1, and the counter returns to 0.
- START: tx_out=0.
- DATA:
  - tx_out = shift register bit 0.
  - At each bit boundary the register shifts right by 1 and bit_idx increments.
  - After the bit_idx=7 period, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx_out = XOR of latched byte, XOR PARITY_ODD.
- STOP:
  - tx_out=1.
  - At end of the period go to IDLE; tx_ready rises in the following cycle.
- tx_out is a registered output, driven from the state and shift register; no glitches.
- Frame length: (10+PARITY_EN)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- Back-to-back frames: at least one IDLE cycle (tx_out=1) separates consecutive frames, even with tx_valid held high.
- tx_data and tx_valid changes during a frame are ignored; the latched byte is unaffected.
- tx_valid held high in IDLE: accepted on the first edge; the producer must drop or update tx_valid after the handshake, otherwise the same byte is sent again.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronous), the frame is abandoned and no byte is retained. After rst deasserts, the block is in IDLE ready to accept.
- CLKS_PER_BIT=1: each bit lasts one cycle; the behaviour above still holds.

Test Plan:
- Reset checks: assert rst mid-cycle with no clock edge -> tx_out=1, tx_ready=1, busy=0 immediately; hold 3 cycles, release -> all outputs unchanged.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0: send tx_data=8'hA5 -> tx_out held for 4 cycles each as 0,1,0,1,0,0,1,0,1,0(parity),1; busy high for 44 cycles; tx_ready low those 44 cycles and high on cycle 45.
- Odd parity and no parity:
  - PARITY_ODD=1, send 8'h07 -> parity bit 0.
  - PARITY_EN=0, send 8'hFF -> frame 40 cycles: start 0, eight 1s, stop 1, no parity slot.
- Back-to-back with tx_valid held high: bytes 8'h01 then 8'h80 -> exactly 1 idle cycle with tx_out=1 between frames; second frame bits 0,0,0,0,0,0,0,0,1,1(parity),1; tx_data changes mid-frame do not corrupt the first frame.
- Reset mid-frame: assert rst during DATA bit_idx=3 -> tx_out=1 the same cycle, busy=0; after release, send 8'h3C -> clean full frame with parity 0.
- CLKS_PER_BIT=1 stress: 16 random bytes streamed -> the serial stream decoded by a bench-side model (or the team's serial-in shift register clocked once per bit) matches the input bytes exactly, with parity correct for each.
